id_imm_stage: RTL and testbench
===============================

# id_imm_stage

IF/ID pipeline stage between instruction fetch and the immediate extender. It buffers fetched instruction/PC pairs in a 2-entry skid buffer with valid/ready handshakes on both sides. It also slices the immediate fields and selects the extension type, so the `EXT` instance downstream receives `Imm5`, `Imm12`, `Imm20` and `EXTSigned` aligned with the instruction it decodes. Flush support discards wrong-path instructions after a taken branch or jump.

## Interface
- `PC_W`, 32, width of the PC carried with each instruction
- `NOP_INST`, 32'h0000_0013, reset and flush value of the held instruction (addi x0,x0,0)

- `clk`  in  1  clock, rising edge
- `rstn`  in  1  asynchronous active-low reset
- `in_valid`  in  1  fetch presents an instruction
- `in_ready`  out  1  stage can accept an instruction
- `in_inst`  in  32  fetched instruction word
- `in_pc`  in  PC_W  PC of `in_inst`
- `flush`  in  1  discard everything held and anything offered this cycle
- `out_valid`  out  1  `out_inst`/`out_pc` hold a live instruction
- `out_ready`  in  1  decode consumes the instruction
- `out_inst`  out  32  held instruction
- `out_pc`  out  PC_W  PC of `out_inst`
- `Imm5`  out  5  `out_inst[11:7]`
- `Imm12`  out  12  `out_inst[31:20]`
- `Imm20`  out  20  `out_inst[31:12]`
- `EXTSigned`  out  2  extension select for `EXT`; encodings are the `ctrl_encode_def.v` macros
- `imm_vld`  out  1  instruction carries an immediate of a supported type
- `illegal`  out  1  `out_valid` and `out_inst[1:0]` != 2'b11

## Operation
- Storage:
  - main register M: valid, inst, pc; drives the `out_*` ports.
  - skid register S: valid, inst, pc.
- `in_ready` = !S.valid. It is driven combinationally from a register and never depends on `out_ready`.
- Transfer on the input side: `in_valid & in_ready`. Transfer on the output side: `out_valid & out_ready`.
- Per edge, without flush:
  - M empty or M consumed, S empty: M loads the input if it transfers, otherwise M.valid goes to 0.
  - M empty or M consumed, S full: M loads S and S empties. `in_ready` was 0, so no input transfers.
  - M full and not consumed: an input transfer loads S.
- Ordering is strict FIFO. No instruction is duplicated or dropped except by flush.
- Flush: on the next edge M.valid = S.valid = 0, M.inst = `NOP_INST` and S.inst = `NOP_INST`. An input offered in the flush cycle is discarded even though `in_ready` = 1.
- Decode is combinational from `out_inst`, using opcode = `out_inst[6:0]`:
  - 0000011, 0010011, 1100111: `EXTSigned` = `ITYPE_EXT`, `imm_vld` = 1.
  - 0100011: `EXTSigned` = `STYPE_EXT`, `imm_vld` = 1.
  - 0110111, 0010111: `EXTSigned` = `UTYPE_EXT`, `imm_vld` = 1.
  - Any other opcode: `EXTSigned` = `ITYPE_EXT`, `imm_vld` = 0.
- Field slicing is fixed and independent of opcode. For S-type, `EXT` uses `Imm12[11:5]` together with `Imm5`.

## Timing
- Reset (asynchronous assert, synchronous release):
  - M.valid = 0, S.valid = 0.
  - M.inst = S.inst = `NOP_INST`; M.pc = S.pc = 0.
  - Resulting outputs: `out_valid` = 0, `in_ready` = 1, `out_inst` = 32'h13, `out_pc` = 0.
  - Resulting decode: `Imm5` = 0, `Imm12` = 0, `Imm20` = 0, `EXTSigned` = `ITYPE_EXT`, `imm_vld` = 1, `illegal` = 0.
- Reset asserted mid-operation drops both entries immediately. There is no partial state.
- Latency: an input accepted at edge N appears on `out_*` after edge N with an empty stage.
- Throughput: with `out_ready` held at 1, one instruction per cycle.
- Stall: when `out_ready` drops, one further input is absorbed into S. `in_ready` falls after that edge.
- Release: the first cycle with `out_ready` = 1 drains S into M. `in_ready` rises after that edge.
- `out_*` and the decode outputs are stable while `out_valid & !out_ready`.
- Flush has priority over every transfer in the same cycle, including an output transfer of M.

## Test plan
- Reset:
  - Stimulus: assert `rstn` low mid-stream with both entries full.
  - Response: `out_valid` = 0 and `in_ready` = 1 immediately, `out_inst` = 32'h00000013; after release the first accepted instruction is the next one presented.
- Streaming:
  - Stimulus: 8 back-to-back instructions with `out_ready` = 1.
  - Response: one output per cycle, 1-cycle latency, `out_pc` = 0x0, 0x4, …, 0x1C in order.
- Backpressure:
  - Stimulus: drop `out_ready` for 3 cycles while `in_valid` is held at 1.
  - Response: exactly 2 instructions held, `in_ready` = 0 from the second stalled cycle; after release they drain in order with no loss and no duplicate.
- Flush:
  - Stimulus: assert `flush` while both entries are full and `in_valid` = 1.
  - Response: next cycle `out_valid` = 0 and `in_ready` = 1; the offered instruction never appears on `out_*`.
- Decode:
  - Stimulus: `out_inst` = 0xFFF00093.
  - Response: `EXTSigned` = `ITYPE_EXT`, `Imm12` = 0xFFF.
  - Stimulus: `out_inst` = 0xFE112E23.
  - Response: `EXTSigned` = `STYPE_EXT`, `Imm12[11:5]` = 0x7F, `Imm5` = 0x1C.
  - Stimulus: `out_inst` = 0x123452B7.
  - Response: `EXTSigned` = `UTYPE_EXT`, `Imm20` = 0x12345.
- Illegal:
  - Stimulus: `out_inst` = 0x00000063.
  - Response: `imm_vld` = 0, `illegal` = 0.
  - Stimulus: `out_inst` = 0x00000000 with `out_valid` = 1.
  - Response: `illegal` = 1.

Source files
------------

// File: rtl/id_imm_stage.sv
// IF/ID stage: 2-entry skid buffer carrying instruction/PC pairs from fetch to
// decode, plus immediate field slicing and extension-type selection for EXT.
module id_imm_stage #(
   parameter int unsigned PC_W     = 32,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [PC_W-1:0] in_pc,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_inst,
   output logic [PC_W-1:0] out_pc,
   output logic [4:0]      Imm5,
   output logic [11:0]     Imm12,
   output logic [19:0]     Imm20,
   output logic [1:0]      EXTSigned,
   output logic            imm_vld,
   output logic            illegal
);

   // Extension selects understood by the downstream EXT block.
   localparam logic [1:0] ITYPE_EXT = 2'b00;
   localparam logic [1:0] STYPE_EXT = 2'b01;
   localparam logic [1:0] UTYPE_EXT = 2'b10;

   logic            m_valid_q, m_valid_d;
   logic [31:0]     m_inst_q,  m_inst_d;
   logic [PC_W-1:0] m_pc_q,    m_pc_d;
   logic            s_valid_q, s_valid_d;
   logic [31:0]     s_inst_q,  s_inst_d;
   logic [PC_W-1:0] s_pc_q,    s_pc_d;

   logic in_xfer;
   logic m_free;

   assign in_ready = ~s_valid_q;
   assign in_xfer  = in_valid & in_ready;
   // M can be overwritten when it is empty or being consumed this cycle.
   assign m_free   = ~m_valid_q | out_ready;

   // Next-state for the main and skid entries; flush overrides every transfer.
   always_comb begin
      m_valid_d = m_valid_q;
      m_inst_d  = m_inst_q;
      m_pc_d    = m_pc_q;
      s_valid_d = s_valid_q;
      s_inst_d  = s_inst_q;
      s_pc_d    = s_pc_q;
      if (flush) begin
         m_valid_d = 1'b0;
         m_inst_d  = NOP_INST;
         s_valid_d = 1'b0;
         s_inst_d  = NOP_INST;
      end else if (m_free) begin
         if (s_valid_q) begin
            m_valid_d = 1'b1;
            m_inst_d  = s_inst_q;
            m_pc_d    = s_pc_q;
            s_valid_d = 1'b0;
         end else if (in_xfer) begin
            m_valid_d = 1'b1;
            m_inst_d  = in_inst;
            m_pc_d    = in_pc;
         end else begin
            m_valid_d = 1'b0;
         end
      end else if (in_xfer) begin
         s_valid_d = 1'b1;
         s_inst_d  = in_inst;
         s_pc_d    = in_pc;
      end
   end

   // State registers with asynchronous reset to an empty stage holding NOPs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_valid_q <= 1'b0;
         m_inst_q  <= NOP_INST;
         m_pc_q    <= '0;
         s_valid_q <= 1'b0;
         s_inst_q  <= NOP_INST;
         s_pc_q    <= '0;
      end else begin
         m_valid_q <= m_valid_d;
         m_inst_q  <= m_inst_d;
         m_pc_q    <= m_pc_d;
         s_valid_q <= s_valid_d;
         s_inst_q  <= s_inst_d;
         s_pc_q    <= s_pc_d;
      end
   end

   assign out_valid = m_valid_q;
   assign out_inst  = m_inst_q;
   assign out_pc    = m_pc_q;

   // Fixed field slices; EXT picks the bits it needs from EXTSigned.
   assign Imm5  = m_inst_q[11:7];
   assign Imm12 = m_inst_q[31:20];
   assign Imm20 = m_inst_q[31:12];

   assign illegal = m_valid_q & (m_inst_q[1:0] != 2'b11);

   // Opcode decode selecting the extension type for the held instruction.
   always_comb begin
      EXTSigned = ITYPE_EXT;
      imm_vld   = 1'b0;
      case (m_inst_q[6:0])
         7'b0000011, 7'b0010011, 7'b1100111: begin
            EXTSigned = ITYPE_EXT;
            imm_vld   = 1'b1;
         end
         7'b0100011: begin
            EXTSigned = STYPE_EXT;
            imm_vld   = 1'b1;
         end
         7'b0110111, 7'b0010111: begin
            EXTSigned = UTYPE_EXT;
            imm_vld   = 1'b1;
         end
         default: begin
            EXTSigned = ITYPE_EXT;
            imm_vld   = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_id_imm_stage.sv
// Directed bench for id_imm_stage: reset, streaming, backpressure, flush, decode.
module tb_id_imm_stage;

   localparam logic [1:0] ITYPE_EXT = 2'b00;
   localparam logic [1:0] STYPE_EXT = 2'b01;
   localparam logic [1:0] UTYPE_EXT = 2'b10;

   logic        clk;
   logic        rstn;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_inst;
   logic [31:0] in_pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic [4:0]  Imm5;
   logic [11:0] Imm12;
   logic [19:0] Imm20;
   logic [1:0]  EXTSigned;
   logic        imm_vld;
   logic        illegal;

   int npass = 0;
   int ntotal = 0;

   id_imm_stage #(
      .PC_W     (32),
      .NOP_INST (32'h0000_0013)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_inst   (in_inst),
      .in_pc     (in_pc),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_inst  (out_inst),
      .out_pc    (out_pc),
      .Imm5      (Imm5),
      .Imm12     (Imm12),
      .Imm20     (Imm20),
      .EXTSigned (EXTSigned),
      .imm_vld   (imm_vld),
      .illegal   (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Advance one rising edge and settle 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Push one instruction with out_ready=1 into an empty stage, then hold it.
   task automatic load(input logic [31:0] inst, input logic [31:0] pc);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_inst   = inst;
      in_pc     = pc;
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      rstn = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
      tick();
      tick();
      // Reset state
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_inst", out_inst, 32'h13);
      chk("rst_out_pc", out_pc, 0);
      chk("rst_imm5", Imm5, 0);
      chk("rst_imm12", Imm12, 0);
      chk("rst_imm20", Imm20, 0);
      chk("rst_ext", EXTSigned, ITYPE_EXT);
      chk("rst_imm_vld", imm_vld, 1);
      chk("rst_illegal", illegal, 0);
      rstn = 1'b1;
      tick();

      // Streaming: 8 back-to-back, 1-cycle latency
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_inst = 32'h0010_0093 + (32'(i) << 20);
         in_pc   = 32'(i) * 4;
         tick();
         chk("stream_valid", out_valid, 1);
         chk("stream_pc", out_pc, 32'(i) * 4);
         chk("stream_inst", out_inst, 32'h0010_0093 + (32'(i) << 20));
      end
      in_valid = 1'b0;
      tick();
      chk("stream_drained", out_valid, 0);

      // Backpressure: A in M, B absorbed into S, C held off
      in_valid = 1'b1; in_inst = 32'h00A0_0093; in_pc = 32'h100;
      tick();
      chk("bp_a_pc", out_pc, 32'h100);
      out_ready = 1'b0;
      in_inst = 32'h00B0_0093; in_pc = 32'h104;
      chk("bp_ready_stall1", in_ready, 1);
      tick();
      in_inst = 32'h00C0_0093; in_pc = 32'h108;
      chk("bp_ready_stall2", in_ready, 0);
      chk("bp_hold_pc2", out_pc, 32'h100);
      tick();
      chk("bp_ready_stall3", in_ready, 0);
      chk("bp_hold_pc3", out_pc, 32'h100);
      tick();
      chk("bp_hold_inst", out_inst, 32'h00A0_0093);
      out_ready = 1'b1;
      tick();
      chk("bp_b_pc", out_pc, 32'h104);
      chk("bp_b_inst", out_inst, 32'h00B0_0093);
      chk("bp_ready_release", in_ready, 1);
      tick();
      chk("bp_c_pc", out_pc, 32'h108);
      chk("bp_c_inst", out_inst, 32'h00C0_0093);
      in_valid = 1'b0;
      tick();
      chk("bp_empty", out_valid, 0);

      // Flush with both entries full and output ready
      in_valid = 1'b1; in_inst = 32'h00D0_0093; in_pc = 32'h200;
      tick();
      out_ready = 1'b0; in_inst = 32'h00E0_0093; in_pc = 32'h204;
      tick();
      chk("fl_full_ready", in_ready, 0);
      flush = 1'b1; out_ready = 1'b1; in_inst = 32'h00F0_0093; in_pc = 32'h208;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_out_valid", out_valid, 0);
      chk("fl_in_ready", in_ready, 1);
      chk("fl_out_inst", out_inst, 32'h13);
      tick();
      chk("fl_nothing_after", out_valid, 0);

      // Flush with M full, S empty: the offered input is dropped despite in_ready=1
      load(32'h0110_0093, 32'h220);
      in_valid = 1'b1; in_inst = 32'h0120_0093; in_pc = 32'h224; flush = 1'b1;
      chk("fl2_in_ready", in_ready, 1);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl2_out_valid", out_valid, 0);
      tick();
      chk("fl2_no_leak", out_valid, 0);

      // Asynchronous reset mid-stream with both entries full
      out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h0130_0093; in_pc = 32'h300;
      tick();
      out_ready = 1'b0; in_inst = 32'h0140_0093; in_pc = 32'h304;
      tick();
      chk("rs_full", in_ready, 0);
      in_valid = 1'b0;
      #2 rstn = 1'b0;
      #1;
      chk("rs_out_valid", out_valid, 0);
      chk("rs_in_ready", in_ready, 1);
      chk("rs_out_inst", out_inst, 32'h13);
      chk("rs_out_pc", out_pc, 0);
      tick();
      rstn = 1'b1;
      tick();
      chk("rs_still_empty", out_valid, 0);
      load(32'h0150_0093, 32'h308);
      chk("rs_next_pc", out_pc, 32'h308);
      chk("rs_next_inst", out_inst, 32'h0150_0093);
      tick();
      chk("rs_stable_pc", out_pc, 32'h308);

      // Decode
      load(32'hFFF0_0093, 32'h400);
      chk("dec_i_ext", EXTSigned, ITYPE_EXT);
      chk("dec_i_imm12", Imm12, 12'hFFF);
      chk("dec_i_vld", imm_vld, 1);
      load(32'hFE11_2E23, 32'h404);
      chk("dec_s_ext", EXTSigned, STYPE_EXT);
      chk("dec_s_imm12hi", Imm12[11:5], 7'h7F);
      chk("dec_s_imm5", Imm5, 5'h1C);
      load(32'h1234_52B7, 32'h408);
      chk("dec_u_ext", EXTSigned, UTYPE_EXT);
      chk("dec_u_imm20", Imm20, 20'h12345);
      chk("dec_u_imm5", Imm5, 5'h05);
      tick();
      chk("dec_u_stable", Imm20, 20'h12345);
      load(32'h0000_0063, 32'h40C);
      chk("ill_br_vld", imm_vld, 0);
      chk("ill_br_ext", EXTSigned, ITYPE_EXT);
      chk("ill_br_illegal", illegal, 0);
      load(32'h0000_0000, 32'h410);
      chk("ill_zero_valid", out_valid, 1);
      chk("ill_zero_illegal", illegal, 1);
      chk("ill_zero_vld", imm_vld, 0);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
